// File: rtl/sim_status_ctrl.sv
// sim_status_ctrl
//   Simulation termination sequencer for the top-level testbench. It watches
//   the driven GPIO pins for software pass/fail signatures and runs a
//   watchdog timeout. It latches a verdict, waits a fixed drain period, and
//   then holds a finish request that the bench wrapper turns into $finish().
//
// Ports
//   clk_i            system clock
//   rst_i            asynchronous, active-high reset
//   enable_i         arms monitoring; low holds the block in IDLE (ignored in DRAIN/DONE)
//   gpio_pins_i      GPIO output value masked by its output enable
//   busy_o           high in RUN or DRAIN
//   verdict_valid_o  sticky once a verdict is latched
//   verdict_o        00 none, 01 pass, 10 fail, 11 timeout
//   verdict_pulse_o  one-cycle pulse on the cycle the verdict becomes visible
//   finish_o         finish request, sticky in DONE
//   cycle_count_o    RUN cycles elapsed, saturating, frozen at verdict
module sim_status_ctrl #(
  parameter logic [31:0] PassSig       = 32'hDEADBEEF,
  parameter logic [31:0] FailSig       = 32'hBAADC0DE,
  parameter int unsigned StableCycles  = 2,
  parameter int unsigned DrainCycles   = 7,
  parameter logic [31:0] TimeoutCycles = 32'd10_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [31:0] gpio_pins_i,
  output logic        busy_o,
  output logic        verdict_valid_o,
  output logic [1:0]  verdict_o,
  output logic        verdict_pulse_o,
  output logic        finish_o,
  output logic [31:0] cycle_count_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [7:0]  StableLim   = 8'(StableCycles);
  localparam logic [31:0] DrainLast   = 32'(DrainCycles) - 32'd1;
  localparam logic [31:0] TimeoutLast = TimeoutCycles - 32'd1;

  state_e      state_q, state_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [7:0]  sig_cnt_q, sig_cnt_d;
  logic        sig_trk_q, sig_trk_d;      // 0: counting PassSig, 1: counting FailSig
  logic [31:0] drain_cnt_q, drain_cnt_d;
  logic [1:0]  verdict_q, verdict_d;
  logic        valid_q, valid_d;
  logic        pulse_q, pulse_d;

  logic        match_pass, match_fail, sig_hit, hit_id;
  logic [7:0]  sig_cnt_nx;
  logic        sig_accept, timeout_hit;

  always_comb begin
    match_pass = (gpio_pins_i == PassSig);
    match_fail = (gpio_pins_i == FailSig);
    sig_hit    = match_pass | match_fail;
    hit_id     = match_fail;

    // Post-increment signature count for this cycle.
    sig_cnt_nx = '0;
    if (sig_hit) begin
      if (hit_id == sig_trk_q) begin
        sig_cnt_nx = (sig_cnt_q == '1) ? sig_cnt_q : sig_cnt_q + 8'd1;
      end else begin
        sig_cnt_nx = 8'd1;
      end
    end

    sig_accept  = sig_hit && (sig_cnt_nx == StableLim);
    timeout_hit = (TimeoutCycles != 32'd0) && (cycle_cnt_q == TimeoutLast);
  end

  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    sig_cnt_d   = sig_cnt_q;
    sig_trk_d   = sig_trk_q;
    drain_cnt_d = drain_cnt_q;
    verdict_d   = verdict_q;
    valid_d     = valid_q;
    pulse_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cycle_cnt_d = '0;
        sig_cnt_d   = '0;
        sig_trk_d   = 1'b0;
        if (enable_i) state_d = S_RUN;
      end

      S_RUN: begin
        if (!enable_i) begin
          state_d     = S_IDLE;
          cycle_cnt_d = '0;
          sig_cnt_d   = '0;
          sig_trk_d   = 1'b0;
        end else begin
          sig_cnt_d = sig_cnt_nx;
          if (sig_hit) sig_trk_d = hit_id;
          // Signature acceptance takes priority over a coincident timeout;
          // the cycle count is frozen on the latching edge.
          if (sig_accept) begin
            verdict_d = hit_id ? 2'b10 : 2'b01;
            valid_d   = 1'b1;
            pulse_d   = 1'b1;
            state_d   = S_DRAIN;
          end else if (timeout_hit) begin
            verdict_d = 2'b11;
            valid_d   = 1'b1;
            pulse_d   = 1'b1;
            state_d   = S_DRAIN;
          end else if (cycle_cnt_q != '1) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
          end
        end
      end

      S_DRAIN: begin
        if (DrainCycles == 0) begin
          state_d = S_DONE;
        end else if (drain_cnt_q == DrainLast) begin
          state_d = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 32'd1;
        end
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cycle_cnt_q <= '0;
      sig_cnt_q   <= '0;
      sig_trk_q   <= 1'b0;
      drain_cnt_q <= '0;
      verdict_q   <= '0;
      valid_q     <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      sig_cnt_q   <= sig_cnt_d;
      sig_trk_q   <= sig_trk_d;
      drain_cnt_q <= drain_cnt_d;
      verdict_q   <= verdict_d;
      valid_q     <= valid_d;
      pulse_q     <= pulse_d;
    end
  end

  always_comb begin
    busy_o          = (state_q == S_RUN) || (state_q == S_DRAIN);
    finish_o        = (state_q == S_DONE);
    verdict_valid_o = valid_q;
    verdict_o       = verdict_q;
    verdict_pulse_o = pulse_q;
    cycle_count_o   = cycle_cnt_q;
  end

endmodule
